// File: rtl/xosera_boot_ctrl.sv
// Reset sequencing and warm-reboot control for the Xosera top level.
// Qualifies PLL lock before releasing reset, then on a reconfigure request
// blanks video, waits for an idle 68k bus and drives SB_WARMBOOT.
module xosera_boot_ctrl #(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned RESET_HOLD_CYCLES  = 16,
    parameter int unsigned BLANK_CYCLES       = 2048,
    parameter int unsigned SEL_SETUP_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset_ni,
    input  logic       pll_lock_i,
    input  logic       bus_cs_n_i,
    input  logic       reconfig_req_i,
    input  logic [1:0] boot_select_i,
    output logic       sys_reset_o,
    output logic       video_blank_o,
    output logic       boot_o,
    output logic [1:0] boot_sel_o,
    output logic       busy_o
);

    localparam int unsigned MAX_AB = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                                     LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int unsigned MAX_CD = (BLANK_CYCLES > SEL_SETUP_CYCLES) ?
                                     BLANK_CYCLES : SEL_SETUP_CYCLES;
    localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SEL_SETUP_CYCLES - 1);

    typedef enum logic [2:0] {
        StLockWait,
        StResetHold,
        StRun,
        StBlank,
        StSetup,
        StBoot
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lock_s1;
    logic             r_lock_s;
    logic             r_cs_n_s1;
    logic             r_cs_n_s;
    logic             r_cs_n_prev;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_bus_idle;

    // Saturating increment so a long bus stall in BLANK cannot wrap the count.
    always_comb begin
        w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
        w_bus_idle = r_cs_n_s & r_cs_n_prev;
    end

    // Two-flop synchronisers for lock and chip select; chip select idles high.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_lock_s1   <= 1'b0;
            r_lock_s    <= 1'b0;
            r_cs_n_s1   <= 1'b1;
            r_cs_n_s    <= 1'b1;
            r_cs_n_prev <= 1'b1;
        end else begin
            r_lock_s1   <= pll_lock_i;
            r_lock_s    <= r_lock_s1;
            r_cs_n_s1   <= bus_cs_n_i;
            r_cs_n_s    <= r_cs_n_s1;
            r_cs_n_prev <= r_cs_n_s;
        end
    end

    // Sequencer: state, shared counter and registered outputs updated together.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state       <= StLockWait;
            r_cnt         <= '0;
            sys_reset_o   <= 1'b1;
            video_blank_o <= 1'b0;
            boot_o        <= 1'b0;
            boot_sel_o    <= 2'b00;
            busy_o        <= 1'b1;
        end else begin
            unique case (r_state)
                StLockWait: begin
                    if (!r_lock_s) begin
                        r_cnt <= '0;
                    end else if (r_cnt == LOCK_LAST) begin
                        r_state <= StResetHold;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                StResetHold: begin
                    if (!r_lock_s) begin
                        r_state <= StLockWait;
                        r_cnt   <= '0;
                    end else if (r_cnt == HOLD_LAST) begin
                        r_state     <= StRun;
                        r_cnt       <= '0;
                        sys_reset_o <= 1'b0;
                        busy_o      <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                StRun: begin
                    // Lock loss takes priority over a same-cycle request.
                    if (!r_lock_s) begin
                        r_state     <= StLockWait;
                        r_cnt       <= '0;
                        sys_reset_o <= 1'b1;
                        busy_o      <= 1'b1;
                    end else if (reconfig_req_i) begin
                        r_state       <= StBlank;
                        r_cnt         <= '0;
                        boot_sel_o    <= boot_select_i;
                        video_blank_o <= 1'b1;
                        busy_o        <= 1'b1;
                    end
                end
                StBlank, StSetup: begin
                    if (!r_lock_s) begin
                        r_state       <= StLockWait;
                        r_cnt         <= '0;
                        sys_reset_o   <= 1'b1;
                        video_blank_o <= 1'b0;
                        boot_sel_o    <= 2'b00;
                    end else if (r_state == StBlank) begin
                        if (r_cnt >= BLANK_LAST && w_bus_idle) begin
                            r_state     <= StSetup;
                            r_cnt       <= '0;
                            sys_reset_o <= 1'b1;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end else if (r_cnt == SETUP_LAST) begin
                        r_state <= StBoot;
                        r_cnt   <= '0;
                        boot_o  <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                StBoot: begin
                    // Terminal: the FPGA reconfigures, only reset_ni leaves here.
                end
                default: begin
                    r_state       <= StLockWait;
                    r_cnt         <= '0;
                    sys_reset_o   <= 1'b1;
                    video_blank_o <= 1'b0;
                    boot_o        <= 1'b0;
                    boot_sel_o    <= 2'b00;
                    busy_o        <= 1'b1;
                end
            endcase
        end
    end

endmodule
